sync_filter_multi: RTL

//  Multi-channel input conditioner for asynchronous control/status lines entering the clk domain.
//  Per channel: STAGES-deep FF synchronizer, then a stability (glitch) filter, then rise/fall pulse

---
 rtl/sync_pkg.sv | 21 ++
 rtl/sync_filter_multi_if.sv | 22 ++
 rtl/sync_filter_chan.sv | 75 +++++++
 rtl/sync_filter_multi.sv | 69 ++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the multi-channel input conditioner: event-source selectors
// and a constant-evaluable ceil(log2) used to size the per-channel stability counter.
package sync_pkg;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_BOTH = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_filter_multi_if.sv
// Signal bundle between the asynchronous-input conditioner and its consumers.
interface sync_filter_multi_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] ev_clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic             any_ev;

  modport master (
    output sig, ev_clr,
    input  out, rise, fall, evt, any_ev
  );

  modport slave (
    input  sig, ev_clr,
    output out, rise, fall, evt, any_ev
  );
endinterface

// File: rtl/sync_filter_chan.sv
// One conditioned channel: synchronizer chain, stability filter, edge pulses and a
// sticky event flag whose set term beats a coincident clear.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter logic INIT       = 1'b0,
  parameter int   FILTER_LEN = 4,
  parameter int   EVENT_EDGE = EV_BOTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic ev_clr,
  output logic out,
  output logic rise,
  output logic fall,
  output logic evt
);

  localparam int            CW       = clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  localparam bit            SET_RISE = (EVENT_EDGE != EV_FALL);
  localparam bit            SET_FALL = (EVENT_EDGE != EV_RISE);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [STAGES-1:0] chain;

  logic          synced;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          out_nxt;
  logic          rise_nxt;
  logic          fall_nxt;
  logic          evt_nxt;

  assign synced = chain[STAGES-1];

  // out only follows synced after it has disagreed for FILTER_LEN consecutive cycles
  always_comb begin
    cnt_nxt  = cnt;
    out_nxt  = out;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (synced == out) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      out_nxt  = synced;
      cnt_nxt  = '0;
      rise_nxt = synced;
      fall_nxt = ~synced;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
    evt_nxt = (SET_RISE && rise_nxt) || (SET_FALL && fall_nxt) || (evt && !ev_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{INIT}};
      cnt   <= '0;
      out   <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
      evt   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], sig};
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      evt   <= evt_nxt;
    end
  end

endmodule

// File: rtl/sync_filter_multi.sv
// Multi-channel conditioner for asynchronous control/status lines: WIDTH independent
// channels plus a registered summary of all sticky event flags.
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int               FILTER_LEN = 4,
  parameter int               EVENT_EDGE = EV_BOTH
) (
  input logic                 clk,
  input logic                 rst_n,
  sync_filter_multi_if.slave  bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_filter_multi: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_multi: STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("sync_filter_multi: FILTER_LEN must be >= 1");
  end
  if (EVENT_EDGE < EV_RISE || EVENT_EDGE > EV_BOTH) begin : g_bad_edge
    $error("sync_filter_multi: EVENT_EDGE must be 0, 1 or 2");
  end

  logic [WIDTH-1:0] out_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] evt_vec;
  logic             any_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES     (STAGES),
      .INIT       (INIT[i]),
      .FILTER_LEN (FILTER_LEN),
      .EVENT_EDGE (EVENT_EDGE)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig    (bus.sig[i]),
      .ev_clr (bus.ev_clr[i]),
      .out    (out_vec[i]),
      .rise   (rise_vec[i]),
      .fall   (fall_vec[i]),
      .evt    (evt_vec[i])
    );
  end

  // Summary flag lags the per-channel flags by one cycle to keep the OR tree off the output path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |evt_vec;
    end
  end

  assign bus.out    = out_vec;
  assign bus.rise   = rise_vec;
  assign bus.fall   = fall_vec;
  assign bus.evt    = evt_vec;
  assign bus.any_ev = any_q;

endmodule
